// File: rtl/wb_collect_arbiter.sv
// rtl/wb_collect_arbiter.sv - per-channel result FIFOs with speculative hold and round-robin writeback grant
module wb_collect_arbiter #(
  parameter int NUM_FU   = 4,
  parameter int WB_PORTS = 2,
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5
) (
  input  logic                                  CLK,
  input  logic                                  nrst,
  input  logic [NUM_FU-1:0]                     fu_valid,
  output logic [NUM_FU-1:0]                     fu_ready,
  input  logic [NUM_FU*DATA_W-1:0]              fu_wdat,
  input  logic [NUM_FU*REG_W-1:0]               fu_reg_sel,
  input  logic [NUM_FU-1:0]                     fu_spec,
  input  logic                                  branch_mispredict,
  input  logic                                  branch_correct,
  output logic [WB_PORTS-1:0]                   wb_valid,
  output logic [WB_PORTS*DATA_W-1:0]            wb_wdat,
  output logic [WB_PORTS*REG_W-1:0]             wb_reg_sel,
  output logic [WB_PORTS*$clog2(NUM_FU)-1:0]    wb_chan,
  output logic [NUM_FU*($clog2(DEPTH)+1)-1:0]   occupancy
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int CHW = $clog2(NUM_FU);

  logic [DATA_W-1:0] mem_wdat [NUM_FU][DEPTH];
  logic [REG_W-1:0]  mem_reg  [NUM_FU][DEPTH];
  logic [DEPTH-1:0]  mem_spec [NUM_FU];
  logic [AW-1:0]     rptr     [NUM_FU];
  logic [AW-1:0]     wptr     [NUM_FU];
  logic [CW-1:0]     count    [NUM_FU];
  // Speculative entries always form a contiguous tail, so a squash is a tail trim by this amount.
  logic [CW-1:0]     spec_cnt [NUM_FU];
  logic [CHW-1:0]    rr_ptr;

  logic [NUM_FU-1:0] push, keep, elig, grant;
  logic [AW-1:0]     base_w        [NUM_FU];
  logic [CW-1:0]     base_cnt      [NUM_FU];
  logic [CW-1:0]     cnt_next      [NUM_FU];
  logic [CW-1:0]     spec_cnt_next [NUM_FU];
  logic [DEPTH-1:0]  spec_next     [NUM_FU];
  int                pos  [NUM_FU];
  int                rank [NUM_FU];
  int                lastc;
  logic [CHW-1:0]    rr_next;

  always_comb begin
    push = '0;
    keep = '0;
    elig = '0;
    occupancy = '0;
    for (int c = 0; c < NUM_FU; c++) begin
      fu_ready[c] = (count[c] != CW'(DEPTH));
      push[c]     = fu_valid[c] & fu_ready[c];
      keep[c]     = push[c] & ~(branch_mispredict & fu_spec[c]);
      elig[c]     = (count[c] != '0) && !mem_spec[c][rptr[c]];
      occupancy[c*CW +: CW] = count[c];
    end
  end

  // Scan position relative to rr_ptr; rank is the number of eligible channels scanned earlier.
  always_comb begin
    grant      = '0;
    wb_valid   = '0;
    wb_wdat    = '0;
    wb_reg_sel = '0;
    wb_chan    = '0;
    lastc      = 0;
    rr_next    = rr_ptr;
    for (int c = 0; c < NUM_FU; c++) begin
      pos[c] = c - int'(rr_ptr);
      if (pos[c] < 0) pos[c] = pos[c] + NUM_FU;
    end
    for (int c = 0; c < NUM_FU; c++) begin
      rank[c] = 0;
      for (int k = 0; k < NUM_FU; k++) begin
        if (elig[k] && pos[k] < pos[c]) rank[c] = rank[c] + 1;
      end
      grant[c] = elig[c] && (rank[c] < WB_PORTS);
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      for (int c = 0; c < NUM_FU; c++) begin
        if (grant[c] && rank[c] == p) begin
          wb_valid[p]                    = 1'b1;
          wb_wdat[p*DATA_W +: DATA_W]    = mem_wdat[c][rptr[c]];
          wb_reg_sel[p*REG_W +: REG_W]   = mem_reg[c][rptr[c]];
          wb_chan[p*CHW +: CHW]          = CHW'(c);
        end
      end
    end
    for (int c = 0; c < NUM_FU; c++) begin
      if (grant[c] && rank[c] == WB_PORTS - 1) lastc = c;
      else if (grant[c] && (rank[c] + 1) == int'($countones(grant))) lastc = c;
    end
    if (grant != '0) rr_next = (lastc == NUM_FU - 1) ? '0 : CHW'(lastc + 1);
  end

  always_comb begin
    for (int c = 0; c < NUM_FU; c++) begin
      base_w[c]   = branch_mispredict ? (wptr[c] - spec_cnt[c][AW-1:0]) : wptr[c];
      base_cnt[c] = branch_mispredict ? (count[c] - spec_cnt[c]) : count[c];
      cnt_next[c] = base_cnt[c] + CW'(keep[c]) - CW'(grant[c]);
      spec_cnt_next[c] = (branch_mispredict || branch_correct) ? '0
                         : spec_cnt[c] + CW'(push[c] & fu_spec[c]);
      spec_next[c] = (branch_mispredict || branch_correct) ? '0 : mem_spec[c];
      if (keep[c]) spec_next[c][base_w[c]] = fu_spec[c] & ~branch_correct & ~branch_mispredict;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      rr_ptr <= '0;
      for (int c = 0; c < NUM_FU; c++) begin
        rptr[c]     <= '0;
        wptr[c]     <= '0;
        count[c]    <= '0;
        spec_cnt[c] <= '0;
        mem_spec[c] <= '0;
      end
    end else begin
      rr_ptr <= rr_next;
      for (int c = 0; c < NUM_FU; c++) begin
        rptr[c]     <= rptr[c] + AW'(grant[c]);
        wptr[c]     <= base_w[c] + AW'(keep[c]);
        count[c]    <= cnt_next[c];
        spec_cnt[c] <= spec_cnt_next[c];
        mem_spec[c] <= spec_next[c];
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int c = 0; c < NUM_FU; c++) begin
      if (nrst && keep[c]) begin
        mem_wdat[c][base_w[c]] <= fu_wdat[c*DATA_W +: DATA_W];
        mem_reg[c][base_w[c]]  <= fu_reg_sel[c*REG_W +: REG_W];
      end
    end
  end

endmodule

// File: tb/tb_wb_collect_arbiter.sv
// tb/tb_wb_collect_arbiter.sv - self-checking bench for wb_collect_arbiter
module tb_wb_collect_arbiter;

  logic         CLK = 1'b0;
  logic         nrst;
  logic [3:0]   fu_valid, fu_ready, fu_spec;
  logic [127:0] fu_wdat;
  logic [19:0]  fu_reg_sel;
  logic         branch_mispredict, branch_correct;
  logic [1:0]   wb_valid;
  logic [63:0]  wb_wdat;
  logic [9:0]   wb_reg_sel;
  logic [3:0]   wb_chan;
  logic [11:0]  occupancy;

  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;

  typedef struct packed {
    logic [1:0]  chan;
    logic [4:0]  rsel;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  spec;
    logic        bm;
    logic        bc;
    logic [31:0] d;
    logic [4:0]  r;
    logic [11:0] exp_occ;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_wbv;
  } vec_t;
  vec_t vecs[10];

  wb_collect_arbiter dut (
    .CLK(CLK), .nrst(nrst),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_wdat(fu_wdat),
    .fu_reg_sel(fu_reg_sel), .fu_spec(fu_spec),
    .branch_mispredict(branch_mispredict), .branch_correct(branch_correct),
    .wb_valid(wb_valid), .wb_wdat(wb_wdat), .wb_reg_sel(wb_reg_sel),
    .wb_chan(wb_chan), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      for (int p = 0; p < 2; p++) begin
        if (wb_valid[p]) begin
          if (sbq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: port %0d chan %0d reg %0d data 0x%0h, expected no write",
                     p, wb_chan[p*2 +: 2], wb_reg_sel[p*5 +: 5], wb_wdat[p*32 +: 32]);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            check("wb_entry", {wb_chan[p*2 +: 2], wb_reg_sel[p*5 +: 5], wb_wdat[p*32 +: 32]}, e);
          end
        end else begin
          check("idle_port_zero", {wb_chan[p*2 +: 2], wb_reg_sel[p*5 +: 5], wb_wdat[p*32 +: 32]}, '0);
        end
      end
    end
  end

  task automatic clear_in();
    fu_valid = '0; fu_spec = '0; fu_wdat = '0; fu_reg_sel = '0;
    branch_mispredict = 1'b0; branch_correct = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic spec, input logic [31:0] d, input logic [4:0] r);
    fu_valid[c] = 1'b1;
    fu_spec[c]  = spec;
    fu_wdat[c*32 +: 32] = d;
    fu_reg_sel[c*5 +: 5] = r;
  endtask

  task automatic expect_wb(input int c, input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    e.chan = 2'(c); e.rsel = r; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK); #1;
    clear_in();
    @(negedge CLK);
  endtask

  task automatic pulse_reset();
    nrst = 1'b0;
    @(posedge CLK); #1;
    nrst = 1'b1;
    @(negedge CLK);
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && sbq.size() != 0; i++) @(negedge CLK);
    #1;
    check(name, sbq.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      vecs[i] = '{4'b0100, 4'b0100, 1'b0, 1'b0, 32'hA000_0000 + i, 5'(10 + i),
                  12'((i < 4 ? i + 1 : 4)) << 6, (i < 3 ? 4'hF : 4'b1011), 2'b00};
    end
    vecs[5] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0, 5'd0, 12'd4 << 6, 4'b1011, 2'b01};
    for (int i = 6; i < 10; i++) begin
      vecs[i] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 5'd0,
                  12'(9 - i) << 6, 4'hF, (i < 9 ? 2'b01 : 2'b00)};
    end

    clear_in();
    nrst = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_occupancy", occupancy, 0);
    check("reset_wb_valid", wb_valid, 0);
    check("reset_wb_wdat", wb_wdat, 0);
    check("reset_wb_reg_sel", wb_reg_sel, 0);
    check("reset_wb_chan", wb_chan, 0);
    check("reset_fu_ready", fu_ready, 4'hF);
    nrst = 1'b1;
    mon_en = 1'b1;

    expect_wb(1, 5'd7, 32'hDEAD_BEEF);
    set_ch(1, 1'b0, 32'hDEAD_BEEF, 5'd7);
    tick();
    check("single_wb_valid", wb_valid, 2'b01);
    check("single_occ", occupancy, 12'd1 << 3);
    tick();
    check("single_occ_after", occupancy, 0);
    drain("drain_single", 4);

    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      expect_wb(c, 5'(c + 1), 32'h1000_0000 + c);
      set_ch(c, 1'b0, 32'h1000_0000 + c, 5'(c + 1));
    end
    tick();
    check("contend_c1_valid", wb_valid, 2'b11);
    check("contend_c1_chan", wb_chan, {2'd1, 2'd0});
    tick();
    check("contend_c2_valid", wb_valid, 2'b11);
    check("contend_c2_chan", wb_chan, {2'd3, 2'd2});
    tick();
    check("contend_empty", occupancy, 0);
    foreach (sbq[i]) ;
    expect_wb(0, 5'd20, 32'h2000_0000);
    expect_wb(1, 5'd21, 32'h2000_0001);
    expect_wb(3, 5'd23, 32'h2000_0003);
    set_ch(0, 1'b0, 32'h2000_0000, 5'd20);
    set_ch(1, 1'b0, 32'h2000_0001, 5'd21);
    set_ch(3, 1'b0, 32'h2000_0003, 5'd23);
    tick();
    check("rr_restart_chan", wb_chan, {2'd1, 2'd0});
    tick();
    check("rr_second_chan", {wb_valid, wb_chan[1:0]}, {2'b01, 2'd3});
    drain("drain_contend", 4);

    for (int i = 0; i < 10; i++) begin
      if (i == 5) for (int k = 0; k < 4; k++) expect_wb(2, 5'(10 + k), 32'hA000_0000 + k);
      fu_valid = vecs[i].valid;
      fu_spec  = vecs[i].spec;
      branch_mispredict = vecs[i].bm;
      branch_correct    = vecs[i].bc;
      for (int c = 0; c < 4; c++) begin
        fu_wdat[c*32 +: 32]  = vecs[i].d;
        fu_reg_sel[c*5 +: 5] = vecs[i].r;
      end
      tick();
      check($sformatf("vec%0d_occ", i), occupancy, vecs[i].exp_occ);
      check($sformatf("vec%0d_ready", i), fu_ready, vecs[i].exp_ready);
      check($sformatf("vec%0d_wbv", i), wb_valid, vecs[i].exp_wbv);
    end
    drain("drain_commit", 4);

    expect_wb(0, 5'd3, 32'h0000_3333);
    set_ch(0, 1'b0, 32'h0000_3333, 5'd3);
    tick();
    set_ch(0, 1'b1, 32'h0000_4444, 5'd4);
    tick();
    set_ch(0, 1'b1, 32'h0000_5555, 5'd5);
    tick();
    check("squash_pre_occ", occupancy, 12'd2);
    set_ch(0, 1'b1, 32'h0000_6666, 5'd6);
    branch_mispredict = 1'b1;
    tick();
    check("squash_occ", occupancy, 0);
    check("squash_ready", fu_ready, 4'hF);
    repeat (3) tick();
    drain("drain_squash", 2);

    set_ch(3, 1'b1, 32'h0000_9999, 5'd9);
    tick();
    check("both_pre_occ", occupancy, 12'd1 << 9);
    check("both_pre_wbv", wb_valid, 2'b00);
    branch_mispredict = 1'b1;
    branch_correct = 1'b1;
    tick();
    check("both_occ", occupancy, 0);
    repeat (3) tick();

    set_ch(1, 1'b1, 32'h0000_2020, 5'd20);
    tick();
    set_ch(1, 1'b1, 32'h0000_2121, 5'd21);
    tick();
    check("midreset_pre_occ", occupancy, 12'd2 << 3);
    pulse_reset();
    check("midreset_occ", occupancy, 0);
    check("midreset_wbv", wb_valid, 2'b00);
    branch_correct = 1'b1;
    tick();
    check("post_reset_commit_occ", occupancy, 0);
    check("post_reset_commit_wbv", wb_valid, 2'b00);
    repeat (2) tick();
    check("final_queue_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
